// File: rtl/writeback_unit_if.sv
// MEM/WB boundary bundle: M-stage fields, data-memory return and the
// register-file write / hazard outputs of the write-back stage.
interface writeback_unit_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    logic                      StallW;
    logic                      FlushM;
    logic                      RegWriteM;
    logic                      MemtoRegM;
    logic [1:0]                LoadSizeM;
    logic                      LoadSignedM;
    logic [2:0]                ByteOffsetM;
    logic [DATA_WIDTH-1:0]     ALUOutM;
    logic [REG_ADDR_WIDTH-1:0] WriteRegM;
    logic [DATA_WIDTH-1:0]     ReadDataW;
    logic                      ReadValidW;
    logic                      RegWriteW;
    logic [REG_ADDR_WIDTH-1:0] WriteRegW;
    logic [DATA_WIDTH-1:0]     ResultW;
    logic                      WaitW;

    modport master (
        output StallW, FlushM, RegWriteM, MemtoRegM, LoadSizeM, LoadSignedM,
               ByteOffsetM, ALUOutM, WriteRegM, ReadDataW, ReadValidW,
        input  RegWriteW, WriteRegW, ResultW, WaitW
    );

    modport slave (
        input  StallW, FlushM, RegWriteM, MemtoRegM, LoadSizeM, LoadSignedM,
               ByteOffsetM, ALUOutM, WriteRegM, ReadDataW, ReadValidW,
        output RegWriteW, WriteRegW, ResultW, WaitW
    );
endinterface

// File: rtl/writeback_unit.sv
// MEM/WB pipeline register with sub-word load alignment/extension and a
// load-wait state machine for a variable-latency data memory.
module writeback_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input logic             CLK,
    input logic             RST,
    writeback_unit_if.slave wb
);
    typedef struct packed {
        logic                      valid;
        logic                      reg_write;
        logic                      mem_to_reg;
        logic [1:0]                load_size;
        logic                      load_signed;
        logic [2:0]                byte_offset;
        logic [DATA_WIDTH-1:0]     alu_out;
        logic [REG_ADDR_WIDTH-1:0] write_reg;
    } mw_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    mw_t    mw_q;
    mw_t    mw_d;
    state_t state_q;
    state_t state_next;
    logic   wait_now;
    logic   advance;
    logic   capture_load;

    logic [1:0]            size_eff;
    logic [2:0]            off_eff;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ext;

    assign wait_now     = mw_q.valid & mw_q.mem_to_reg & ~wb.ReadValidW;
    assign advance      = ~wb.StallW & ~wait_now;
    assign capture_load = ~wb.FlushM & wb.MemtoRegM;

    // M-stage fields, or an all-zero bubble on flush
    always_comb begin
        mw_d = '0;
        if (!wb.FlushM) begin
            mw_d.valid       = 1'b1;
            mw_d.reg_write   = wb.RegWriteM;
            mw_d.mem_to_reg  = wb.MemtoRegM;
            mw_d.load_size   = wb.LoadSizeM;
            mw_d.load_signed = wb.LoadSignedM;
            mw_d.byte_offset = wb.ByteOffsetM;
            mw_d.alu_out     = wb.ALUOutM;
            mw_d.write_reg   = wb.WriteRegM;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mw_q <= '0;
        end else if (advance) begin
            mw_q <= mw_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE: if (advance && capture_load) state_next = ST_WAIT;
            ST_WAIT: if (advance && wb.ReadValidW && !capture_load) state_next = ST_IDLE;
        endcase
    end

    // Outputs are combinational from the register and the memory return
    always_comb begin
        size_eff = mw_q.load_size;
        if (DATA_WIDTH == 32 && size_eff == 2'b11) size_eff = 2'b10;

        case (size_eff)
            2'b00:   off_eff = mw_q.byte_offset;
            2'b01:   off_eff = mw_q.byte_offset & 3'b110;
            2'b10:   off_eff = mw_q.byte_offset & 3'b100;
            default: off_eff = 3'b000;
        endcase
        if (DATA_WIDTH == 32) off_eff[2] = 1'b0;

        shifted = wb.ReadDataW >> {off_eff, 3'b000};

        ext = shifted;
        case (size_eff)
            2'b00: begin
                if (mw_q.load_signed) ext = DATA_WIDTH'($signed(shifted[7:0]));
                else                  ext = DATA_WIDTH'(shifted[7:0]);
            end
            2'b01: begin
                if (mw_q.load_signed) ext = DATA_WIDTH'($signed(shifted[15:0]));
                else                  ext = DATA_WIDTH'(shifted[15:0]);
            end
            2'b10: begin
                if (mw_q.load_signed) ext = DATA_WIDTH'($signed(shifted[31:0]));
                else                  ext = DATA_WIDTH'(shifted[31:0]);
            end
            default: ext = shifted;
        endcase

        wb.WaitW     = wait_now;
        wb.RegWriteW = mw_q.valid & mw_q.reg_write & ~wait_now & (mw_q.write_reg != '0);
        wb.WriteRegW = mw_q.write_reg;
        wb.ResultW   = mw_q.mem_to_reg ? ext : mw_q.alu_out;
    end
endmodule

// File: tb/tb_writeback_unit.sv
// Directed checks of the write-back stage, then randomized traffic scored
// against an instruction-level reference model.
module tb_writeback_unit;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    writeback_unit_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) wb ();
    writeback_unit #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .CLK(CLK),
        .RST(RST),
        .wb (wb)
    );

    typedef struct {
        bit        rw;
        bit        ld;
        bit [1:0]  sz;
        bit        sg;
        bit [2:0]  off;
        bit [31:0] alu;
        bit [4:0]  rd;
        bit [31:0] mdata;
        int        lat;
    } instr_t;

    typedef struct {
        bit [4:0]  rd;
        bit [31:0] res;
    } wr_t;

    int     total = 0;
    int     bad   = 0;
    wr_t    exp_q[$];
    bit     sb_on    = 1'b0;
    bit     exp_wait = 1'b0;
    instr_t m_i, w_i, nop;
    bit     w_valid, adv, stall, flush, rv;
    int     w_cnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic instr_t mk(input bit rw, input bit ld, input bit [1:0] sz, input bit sg,
                                  input bit [2:0] off, input bit [31:0] alu, input bit [4:0] rd);
        instr_t i;
        i.rw = rw; i.ld = ld; i.sz = sz; i.sg = sg; i.off = off;
        i.alu = alu; i.rd = rd; i.mdata = 32'h0; i.lat = 0;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.rw    = ($urandom % 4) != 0;
        i.ld    = 1'($urandom);
        i.sz    = 2'($urandom);
        i.sg    = 1'($urandom);
        i.off   = 3'($urandom);
        i.alu   = $urandom;
        i.rd    = 5'($urandom);
        i.mdata = $urandom;
        i.lat   = int'($urandom % 4);
        return i;
    endfunction

    // Load result from byte-lane arithmetic: align offset down to the access size
    function automatic bit [31:0] ref_result(input instr_t i);
        int     nb, o;
        longint v, lim;
        if (!i.ld) return i.alu;
        nb = (i.sz == 2'd0) ? 1 : (i.sz == 2'd1) ? 2 : 4;
        o  = ((int'(i.off) % 4) / nb) * nb;
        v  = longint'(i.mdata) >> (8 * o);
        if (nb < 4) begin
            lim = longint'(1) << (8 * nb);
            v   = v % lim;
            if (i.sg && v >= lim / 2) v = v - lim;
        end
        return 32'(v);
    endfunction

    task automatic set_m(input instr_t i);
        wb.RegWriteM   = i.rw;
        wb.MemtoRegM   = i.ld;
        wb.LoadSizeM   = i.sz;
        wb.LoadSignedM = i.sg;
        wb.ByteOffsetM = i.off;
        wb.ALUOutM     = i.alu;
        wb.WriteRegM   = i.rd;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " regwrite"}, 32'(wb.RegWriteW), 32'd0);
        check({tag, " writereg"}, 32'(wb.WriteRegW), 32'd0);
        check({tag, " result"},   wb.ResultW,        32'd0);
        check({tag, " wait"},     32'(wb.WaitW),     32'd0);
    endtask

    // One randomized cycle: drive, predict, then advance the model on the edge
    task automatic run_cycle(input bit drain);
        wr_t e;
        stall = drain ? 1'b0 : (($urandom % 5) == 0);
        flush = drain ? 1'b1 : (($urandom % 8) == 0);
        wb.StallW = stall;
        wb.FlushM = flush;
        set_m(m_i);
        if (w_valid && w_i.ld) begin
            rv = (w_cnt == 0);
            wb.ReadDataW = rv ? w_i.mdata : $urandom;
        end else begin
            rv = 1'($urandom);
            wb.ReadDataW = $urandom;
        end
        wb.ReadValidW = rv;
        exp_wait = w_valid && w_i.ld && !rv;
        adv = !stall && !exp_wait;
        if (adv && !flush && m_i.rw && m_i.rd != 5'd0) begin
            e.rd  = m_i.rd;
            e.res = ref_result(m_i);
            exp_q.push_back(e);
        end
        @(posedge CLK);
        if (adv) begin
            if (flush) w_valid = 1'b0;
            else begin
                w_i = m_i; w_valid = 1'b1; w_cnt = m_i.lat;
            end
            m_i = rand_instr();
        end else if (w_valid && w_i.ld && w_cnt > 0) begin
            w_cnt--;
        end
        #1;
    endtask

    // Scoreboard monitor: one pop per write that leaves the stage
    always @(negedge CLK) begin
        if (sb_on) begin
            total++;
            if (wb.WaitW !== exp_wait) begin
                bad++;
                $display("FAIL waitw: got %b want %b", wb.WaitW, exp_wait);
            end
            if (wb.RegWriteW === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra write: got reg %0d data %h want none", wb.WriteRegW, wb.ResultW);
                end else begin
                    if (wb.WriteRegW !== exp_q[0].rd || wb.ResultW !== exp_q[0].res) begin
                        bad++;
                        $display("FAIL write: got reg %0d data %h want reg %0d data %h",
                                 wb.WriteRegW, wb.ResultW, exp_q[0].rd, exp_q[0].res);
                    end
                    if (!wb.StallW) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        nop = mk(1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 5'd0);
        set_m(nop);
        wb.StallW = 1'b0; wb.FlushM = 1'b0;
        wb.ReadValidW = 1'b0; wb.ReadDataW = 32'h0;
        #12;
        check_zero("reset");
        @(negedge CLK) RST = 1'b1;

        // ALU op
        set_m(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 32'h1234_5678, 5'd9));
        step(); set_m(nop);
        check("alu regwrite", 32'(wb.RegWriteW), 32'd1);
        check("alu writereg", 32'(wb.WriteRegW), 32'd9);
        check("alu result",   wb.ResultW,        32'h1234_5678);

        // signed then unsigned byte load at offset 3
        set_m(mk(1'b1, 1'b1, 2'd0, 1'b1, 3'd3, 32'h0, 5'd4));
        step();
        set_m(mk(1'b1, 1'b1, 2'd0, 1'b0, 3'd3, 32'h0, 5'd4));
        wb.ReadValidW = 1'b1; wb.ReadDataW = 32'h80FF_0000;
        #1;
        check("sbyte result",   wb.ResultW,        32'hFFFF_FF80);
        check("sbyte regwrite", 32'(wb.RegWriteW), 32'd1);
        check("sbyte writereg", 32'(wb.WriteRegW), 32'd4);
        check("sbyte wait",     32'(wb.WaitW),     32'd0);
        step();
        check("ubyte result",   wb.ResultW,        32'h0000_0080);
        set_m(nop);
        step();
        check("rv ignored regwrite", 32'(wb.RegWriteW), 32'd0);
        check("rv ignored wait",     32'(wb.WaitW),     32'd0);
        wb.ReadValidW = 1'b0;

        // memory latency 3
        set_m(mk(1'b1, 1'b1, 2'd2, 1'b0, 3'd0, 32'h0, 5'd5));
        step(); set_m(nop); #1;
        check("lat c1 wait",     32'(wb.WaitW),     32'd1);
        check("lat c1 regwrite", 32'(wb.RegWriteW), 32'd0);
        step();
        check("lat c2 wait",     32'(wb.WaitW),     32'd1);
        check("lat c2 regwrite", 32'(wb.RegWriteW), 32'd0);
        step();
        wb.ReadValidW = 1'b1; wb.ReadDataW = 32'hDEAD_BEEF; #1;
        check("lat c3 regwrite", 32'(wb.RegWriteW), 32'd1);
        check("lat c3 result",   wb.ResultW,        32'hDEAD_BEEF);
        check("lat c3 wait",     32'(wb.WaitW),     32'd0);
        step(); wb.ReadValidW = 1'b0;

        // back-to-back zero-latency loads then ALU op
        set_m(mk(1'b1, 1'b1, 2'd1, 1'b1, 3'd2, 32'h0, 5'd6));
        step();
        set_m(mk(1'b1, 1'b1, 2'd0, 1'b0, 3'd1, 32'h0, 5'd7));
        wb.ReadValidW = 1'b1; wb.ReadDataW = 32'h8001_7F00; #1;
        check("b2b1 writereg", 32'(wb.WriteRegW), 32'd6);
        check("b2b1 result",   wb.ResultW,        32'hFFFF_8001);
        check("b2b1 regwrite", 32'(wb.RegWriteW), 32'd1);
        step();
        set_m(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 32'h0000_00A5, 5'd8));
        wb.ReadDataW = 32'h0000_C300; #1;
        check("b2b2 writereg", 32'(wb.WriteRegW), 32'd7);
        check("b2b2 result",   wb.ResultW,        32'h0000_00C3);
        step();
        wb.ReadValidW = 1'b0; set_m(nop); #1;
        check("b2b3 regwrite", 32'(wb.RegWriteW), 32'd1);
        check("b2b3 writereg", 32'(wb.WriteRegW), 32'd8);
        check("b2b3 result",   wb.ResultW,        32'h0000_00A5);
        check("b2b3 wait",     32'(wb.WaitW),     32'd0);
        step();

        // register 0 destination
        set_m(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 32'h0000_55AA, 5'd0));
        step(); set_m(nop);
        check("r0 regwrite", 32'(wb.RegWriteW), 32'd0);
        check("r0 result",   wb.ResultW,        32'h0000_55AA);

        // flush
        set_m(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 32'h1, 5'd10));
        wb.FlushM = 1'b1;
        step(); wb.FlushM = 1'b0; set_m(nop);
        check_zero("flush");

        // stall together with flush holds W
        set_m(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 32'h77, 5'd11));
        step();
        wb.StallW = 1'b1; wb.FlushM = 1'b1;
        set_m(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 32'h99, 5'd12));
        step();
        check("stallflush writereg", 32'(wb.WriteRegW), 32'd11);
        check("stallflush result",   wb.ResultW,        32'h77);
        check("stallflush regwrite", 32'(wb.RegWriteW), 32'd1);
        wb.StallW = 1'b0; wb.FlushM = 1'b0; set_m(nop);
        step();

        // reset while waiting on a load
        set_m(mk(1'b1, 1'b1, 2'd2, 1'b0, 3'd0, 32'h0, 5'd13));
        step(); set_m(nop); #1;
        check("prereset wait", 32'(wb.WaitW), 32'd1);
        RST = 1'b0; #1;
        check_zero("reset in wait");
        @(negedge CLK) RST = 1'b1;

        // randomized scoreboard phase
        @(posedge CLK); #1;
        w_valid = 1'b0; w_cnt = 0;
        m_i = rand_instr();
        sb_on = 1'b1;
        repeat (3000) run_cycle(1'b0);
        repeat (8) run_cycle(1'b1);
        sb_on = 1'b0;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
